// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream multiplexer.
// Contents: mux_state_e (arbiter FSM states), rr_pick (round-robin one-hot pick).
package stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mux_state_e;

  // rr_pick works on a fixed maximum channel count; callers zero-extend.
  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MAX_IDXW = 5;
  localparam int unsigned MAX_CHW  = 6;

  // First valid channel scanning ptr+1, ptr+2, ... modulo ch, as a one-hot vector.
  function automatic logic [MAX_CH-1:0] rr_pick(
    input logic [MAX_CH-1:0]   valid,
    input logic [MAX_IDXW-1:0] ptr,
    input logic [MAX_CHW-1:0]  ch
  );
    logic               found;
    logic [MAX_CHW-1:0] idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      idx = MAX_CHW'(ptr) + MAX_CHW'(i);
      if (idx >= ch) idx = idx - ch;
      if ((MAX_CHW'(i) <= ch) && !found && valid[idx[MAX_IDXW-1:0]]) begin
        rr_pick[idx[MAX_IDXW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin after ptr, or fixed priority (lowest index).
// Ports: valid (per-channel request), ptr (last completed winner), prio_mode,
//        grant (one-hot), grant_idx (index of the granted channel, 0 if none).
module rr_arbiter
  import stream_pkg::*;
#(
  parameter  int unsigned CH   = 4,
  localparam int unsigned SELW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic [CH-1:0]   valid,
  input  logic [SELW-1:0] ptr,
  input  logic            prio_mode,
  output logic [CH-1:0]   grant,
  output logic [SELW-1:0] grant_idx
);

  logic [MAX_CH-1:0] rr_grant;
  logic [CH-1:0]     fp_grant;
  logic              unused_rr_bits;

  assign rr_grant       = rr_pick(MAX_CH'(valid), MAX_IDXW'(ptr), MAX_CHW'(CH));
  assign unused_rr_bits = ^rr_grant;

  // Fixed priority: lowest-index valid channel.
  always_comb begin
    logic found;
    fp_grant = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (valid[i] && !found) begin
        fp_grant[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign grant = prio_mode ? fp_grant : rr_grant[CH-1:0];

  // One-hot to index.
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (grant[i]) grant_idx = SELW'(i);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// CH-input valid/ready stream multiplexer with registered output and optional
// packet locking (grant held from first beat until the in_last beat).
// Ports: clk, rst_n (sync, active-low), prio_mode (0 rr / 1 fixed),
//        in_data/in_valid/in_last/in_ready (per channel, channel c at [c*N +: N]),
//        out_data/out_valid/out_last/out_sel/out_ready (registered output side),
//        busy (packet lock held).
module stream_mux_rr
  import stream_pkg::*;
#(
  parameter  int unsigned N        = 8,
  parameter  int unsigned CH       = 4,
  parameter  int unsigned LOCK_PKT = 1,
  localparam int unsigned SELW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            prio_mode,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH-1:0]   in_last,
  output logic [CH-1:0]   in_ready,
  output logic [N-1:0]    out_data,
  output logic            out_valid,
  output logic            out_last,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready,
  output logic            busy
);

  mux_state_e      state, state_next;
  logic [SELW-1:0] rr_ptr, lock_ch, arb_idx, gnt_idx;
  logic [CH-1:0]   arb_grant, grant;
  logic            load_en, xfer, pkt_done;
  logic [N-1:0]    ch_data [CH];

  for (genvar c = 0; c < CH; c++) begin : g_unpack
    assign ch_data[c] = in_data[c*N +: N];
  end

  rr_arbiter #(.CH(CH)) u_arb (
    .valid     (in_valid),
    .ptr       (rr_ptr),
    .prio_mode (prio_mode),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // While locked only the owning channel may be granted, whatever prio_mode says.
  always_comb begin
    grant   = arb_grant;
    gnt_idx = arb_idx;
    if (state == LOCKED) begin
      grant          = '0;
      grant[lock_ch] = in_valid[lock_ch];
      gnt_idx        = lock_ch;
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = load_en ? grant : '0;
  assign xfer     = load_en && (|grant);
  assign pkt_done = xfer && in_last[gnt_idx];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if ((LOCK_PKT != 0) && xfer && !in_last[gnt_idx]) state_next = LOCKED;
      LOCKED:  if (pkt_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Arbitration bookkeeping and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= SELW'(CH - 1);
      lock_ch   <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      busy <= (state_next == LOCKED);
      if ((state == IDLE) && xfer) lock_ch <= gnt_idx;
      if (pkt_done || ((LOCK_PKT == 0) && xfer)) rr_ptr <= gnt_idx;
      if (load_en) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= ch_data[gnt_idx];
          out_last <= in_last[gnt_idx];
          out_sel  <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: one packet-locking and one per-beat instance share
// the same inputs and are compared against a transaction-level model.
module tb_stream_mux_rr;

  localparam int unsigned N    = 8;
  localparam int unsigned CH   = 4;
  localparam int unsigned SELW = 2;

  logic            clk = 1'b0;
  logic            rst_n, prio_mode, out_ready;
  logic [CH*N-1:0] in_data;
  logic [CH-1:0]   in_valid, in_last;

  // Index 1: LOCK_PKT=1, index 0: LOCK_PKT=0.
  logic [CH-1:0]   rdy   [2];
  logic [N-1:0]    odata [2];
  logic            ovalid[2];
  logic            olast [2];
  logic            obusy [2];
  logic [SELW-1:0] osel  [2];

  stream_mux_rr #(.N(N), .CH(CH), .LOCK_PKT(1)) dut_lk (
    .clk(clk), .rst_n(rst_n), .prio_mode(prio_mode), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[1]),
    .out_data(odata[1]), .out_valid(ovalid[1]), .out_last(olast[1]),
    .out_sel(osel[1]), .out_ready(out_ready), .busy(obusy[1])
  );

  stream_mux_rr #(.N(N), .CH(CH), .LOCK_PKT(0)) dut_nl (
    .clk(clk), .rst_n(rst_n), .prio_mode(prio_mode), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy[0]),
    .out_data(odata[0]), .out_valid(ovalid[0]), .out_last(olast[0]),
    .out_sel(osel[0]), .out_ready(out_ready), .busy(obusy[0])
  );

  always #5 clk = ~clk;

  // Reference model state per instance.
  bit          m_valid [2];
  bit          m_last  [2];
  bit          m_locked[2];
  logic [N-1:0] m_data [2];
  int          m_sel    [2];
  int          m_lock_ch[2];
  int          m_ptr    [2];
  int          last_g   [2];
  int          checks = 0;
  int          errors = 0;
  bit          known  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel granted this cycle (or -1): what the spec's arbitration rules pick.
  function automatic int model_pick(input int k);
    if (m_valid[k] && !out_ready) return -1;
    if (m_locked[k]) return in_valid[SELW'(m_lock_ch[k])] ? m_lock_ch[k] : -1;
    if (prio_mode) begin
      for (int c = 0; c < int'(CH); c++) if (in_valid[SELW'(c)]) return c;
      return -1;
    end
    for (int d = 1; d <= int'(CH); d++) begin
      int c;
      c = (m_ptr[k] + d) % int'(CH);
      if (in_valid[SELW'(c)]) return c;
    end
    return -1;
  endfunction

  task automatic model_update(input int k, input int g);
    bit lb;
    if (!rst_n) begin
      m_valid[k] = 0; m_data[k] = '0; m_last[k] = 0; m_sel[k] = 0;
      m_locked[k] = 0; m_lock_ch[k] = 0; m_ptr[k] = CH - 1;
      return;
    end
    if (m_valid[k] && !out_ready) return;
    if (g < 0) begin
      m_valid[k] = 0;
      return;
    end
    lb = in_last[SELW'(g)];
    m_valid[k] = 1; m_data[k] = in_data[g*N +: N]; m_last[k] = lb; m_sel[k] = g;
    if (k == 1) begin
      if (!m_locked[k] && !lb) begin
        m_locked[k] = 1; m_lock_ch[k] = g;
      end else if (m_locked[k] && lb) begin
        m_locked[k] = 0;
      end
    end
    if (lb || k == 0) m_ptr[k] = g;
  endtask

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic tick();
    int g[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      g[k] = model_pick(k);
      if (known) check($sformatf("in_ready[%0d]", k), 32'(rdy[k]),
                       (g[k] < 0) ? 32'd0 : (32'd1 << g[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      model_update(k, g[k]);
      last_g[k] = rst_n ? g[k] : -1;
    end
    known = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("out_valid[%0d]", k), 32'(ovalid[k]), 32'(m_valid[k]));
      check($sformatf("out_data[%0d]", k),  32'(odata[k]),  32'(m_data[k]));
      check($sformatf("out_last[%0d]", k),  32'(olast[k]),  32'(m_last[k]));
      check($sformatf("out_sel[%0d]", k),   32'(osel[k]),   32'(m_sel[k]));
      check($sformatf("busy[%0d]", k),      32'(obusy[k]),  32'(m_locked[k]));
    end
    @(negedge clk);
  endtask

  task automatic set_ch(input int c, input bit v, input logic [N-1:0] d, input bit l);
    in_valid[SELW'(c)] = v;
    in_last[SELW'(c)]  = l;
    in_data[c*N +: N]  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; prio_mode = 0; out_ready = 1;
    in_data = '0; in_valid = '0; in_last = '0;
    @(negedge clk);
    tick(); tick();
    rst_n = 1;

    // Idle after reset.
    repeat (5) begin
      tick();
      check("idle_out_valid", 32'(ovalid[1]), 32'd0);
      check("idle_in_ready", 32'(rdy[1]), 32'd0);
    end

    // Round-robin fairness, single-beat packets on all channels.
    in_valid = '1; in_last = '1; in_data = 32'h40302010;
    for (int i = 0; i < 8; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        check("rr_sel", 32'(osel[k]), 32'(i % 4));
        check("rr_data", 32'(odata[k]), 32'((i % 4 + 1) * 16));
      end
    end

    // Packet lock: ch2 three-beat packet while ch0 joins.
    in_valid = '0; in_last = '0;
    set_ch(2, 1, 8'hC0, 0);
    tick();
    check("lock_sel1", 32'(osel[1]), 32'd2);
    check("lock_busy1", 32'(obusy[1]), 32'd1);
    set_ch(0, 1, 8'h01, 1);
    set_ch(2, 1, 8'hC1, 0);
    tick();
    check("lock_sel2", 32'(osel[1]), 32'd2);
    check("lock_data2", 32'(odata[1]), 32'hC1);
    check("lock_busy2", 32'(obusy[1]), 32'd1);
    set_ch(2, 1, 8'hC2, 1);
    tick();
    check("lock_sel3", 32'(osel[1]), 32'd2);
    check("lock_last3", 32'(olast[1]), 32'd1);
    check("lock_busy3", 32'(obusy[1]), 32'd0);
    set_ch(2, 0, 8'h00, 0);
    tick();
    check("lock_after_sel", 32'(osel[1]), 32'd0);
    check("lock_after_data", 32'(odata[1]), 32'h01);

    // Fixed priority with ch1 and ch3 continuously valid.
    in_valid = '0; in_last = '1; prio_mode = 1;
    set_ch(1, 1, 8'h11, 1);
    set_ch(3, 1, 8'h33, 1);
    repeat (6) begin
      tick();
      check("fp_sel", 32'(osel[1]), 32'd1);
      check("fp_ready3", 32'(rdy[1][3]), 32'd0);
    end

    // Back-pressure holding 0xA5.
    prio_mode = 0; in_valid = '0; in_last = '0;
    set_ch(0, 1, 8'hA5, 1);
    tick();
    out_ready = 0;
    set_ch(0, 0, 8'h00, 0);
    set_ch(1, 1, 8'h5A, 1);
    repeat (4) begin
      tick();
      check("bp_data", 32'(odata[1]), 32'hA5);
      check("bp_valid", 32'(ovalid[1]), 32'd1);
      check("bp_ready", 32'(rdy[1]), 32'd0);
    end
    out_ready = 1;
    tick();
    check("bp_release_data", 32'(odata[1]), 32'h5A);
    check("bp_release_sel", 32'(osel[1]), 32'd1);

    // Mid-packet reset of a ch1 packet.
    in_valid = '0; in_last = '0;
    set_ch(1, 1, 8'hB0, 0);
    tick();
    check("mpr_busy", 32'(obusy[1]), 32'd1);
    set_ch(1, 1, 8'hB1, 0);
    tick();
    rst_n = 0;
    tick();
    check("mpr_valid", 32'(ovalid[1]), 32'd0);
    check("mpr_busy0", 32'(obusy[1]), 32'd0);
    rst_n = 1;
    set_ch(0, 1, 8'h0A, 1);
    set_ch(1, 1, 8'hB2, 0);
    tick();
    check("mpr_first_sel", 32'(osel[1]), 32'd0);
    check("mpr_first_data", 32'(odata[1]), 32'h0A);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = CH'($urandom);
      for (int c = 0; c < int'(CH); c++) in_last[SELW'(c)] = ($urandom_range(0, 2) == 0);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) prio_mode = ~prio_mode;
      rst_n     = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
